// File: rtl/field_ordering_dup_check_pkg.sv
// Shared field-ordering definitions: data-word field split, CLOG2 and the
// checker's FSM state type.
`ifndef FO_FIELD_MACROS
`define FO_FIELD_MACROS
`define CLOG2(x) $clog2(x)
`define FO_KEY(word, IW, KW) word[(IW) +: (KW)]
`define FO_INDEX(word, IW) word[(IW)-1:0]
`endif

package field_ordering_dup_check_pkg;

    localparam int FO_INT_WIDTH_DEF   = 32;
    localparam int FO_INDEX_WIDTH_DEF = 13;
    localparam int FO_LIST_LEN_DEF    = 8192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fod_state_e;

endpackage

// File: rtl/field_ordering_dup_check_if.sv
// Bundle of the sorter read port, the permutation stream and the controller
// handshake seen by field_ordering_dup_check.
interface field_ordering_dup_check_if
    import field_ordering_dup_check_pkg::*;
#(
    parameter int INT_WIDTH   = FO_INT_WIDTH_DEF,
    parameter int INDEX_WIDTH = FO_INDEX_WIDTH_DEF,
    parameter int LIST_LEN    = FO_LIST_LEN_DEF
) ();
    localparam int ADDR_W = `CLOG2(LIST_LEN);

    logic                           start;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic [INT_WIDTH+INDEX_WIDTH-1:0] data_in;
    logic [INDEX_WIDTH-1:0]         index_out;
    logic                           index_valid;
    logic                           index_ready;
    logic                           index_last;
    logic                           done;
    logic                           fail;

    modport master (
        input  start, data_in, index_ready,
        output rd_en, rd_addr, index_out, index_valid, index_last, done, fail
    );

    modport slave (
        output start, data_in, index_ready,
        input  rd_en, rd_addr, index_out, index_valid, index_last, done, fail
    );
endinterface

// File: rtl/field_ordering_dup_check_fifo_2entry.sv
// Two-entry FIFO with a registered head; flush empties it in one cycle.
module fifo_2entry
    import field_ordering_dup_check_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        slot0_d = din;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0_d = din;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end else if (push) begin
                        slot1_d = din;
                        count_d = 2'd2;
                    end
                end
                default: begin
                    // Full: a push is only legal together with a pop.
                    if (pop) begin
                        slot0_d = slot1_q;
                        if (push) begin
                            slot1_d = din;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head       = slot0_q;
    assign head_valid = (count_q != 2'd0);
    assign count      = count_q;
endmodule

// File: rtl/field_ordering_dup_check.sv
// Streams the sorted {key, index} list out of merge_sort, aborts on equal
// adjacent keys and otherwise emits the indices as the permutation stream.
module field_ordering_dup_check
    import field_ordering_dup_check_pkg::*;
#(
    parameter int INT_WIDTH   = FO_INT_WIDTH_DEF,
    parameter int INDEX_WIDTH = FO_INDEX_WIDTH_DEF,
    parameter int LIST_LEN    = FO_LIST_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    field_ordering_dup_check_if.master bus
);
    localparam int ADDR_W  = `CLOG2(LIST_LEN);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = INDEX_WIDTH + 1;

    fod_state_e             state_q, state_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic                   inflight_q, inflight_d;
    logic                   ret_last_q, ret_last_d;
    logic [INT_WIDTH-1:0]   prev_int_q, prev_int_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   fail_q, fail_d;
    logic                   done_q, done_d;

    logic [INT_WIDTH-1:0]   key_in;
    logic [INDEX_WIDTH-1:0] idx_in;
    logic                   running;
    logic                   dup;
    logic                   rd_issue;
    logic [2:0]             occ;
    logic [2:0]             occ_lim;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [ENTRY_W-1:0]     fifo_din;
    logic [ENTRY_W-1:0]     fifo_head;
    logic                   fifo_valid;
    logic [1:0]             fifo_count;
    logic                   out_valid;

    assign key_in  = `FO_KEY(bus.data_in, INDEX_WIDTH, INT_WIDTH);
    assign idx_in  = `FO_INDEX(bus.data_in, INDEX_WIDTH);
    assign running = (state_q == ST_RUN);

    // A duplicate suppresses the head in the same cycle so the word before it is never emitted either.
    assign dup       = running && inflight_q && prev_valid_q && (key_in == prev_int_q);
    assign out_valid = fifo_valid && !dup;
    assign fifo_pop  = out_valid && bus.index_ready;
    assign fifo_push = running && inflight_q && !dup;
    assign fifo_din  = {idx_in, ret_last_q};

    // FIFO slots plus the outstanding read may never exceed two.
    assign occ      = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign occ_lim  = 3'd2 + {2'b00, fifo_pop};
    assign rd_issue = running && !dup && (rd_ptr_q < PTR_W'(LIST_LEN)) && (occ < occ_lim);

    fifo_2entry #(.WIDTH(ENTRY_W)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (dup),
        .din        (fifo_din),
        .head       (fifo_head),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        ret_last_d   = ret_last_q;
        prev_int_d   = prev_int_q;
        prev_valid_d = prev_valid_q;
        fail_d       = fail_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    fail_d       = 1'b0;
                    rd_ptr_d     = '0;
                    inflight_d   = 1'b0;
                    prev_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                inflight_d = rd_issue;
                if (rd_issue) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    ret_last_d = (rd_ptr_q == PTR_W'(LIST_LEN - 1));
                end
                if (dup) begin
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (inflight_q) begin
                    prev_int_d   = key_in;
                    prev_valid_d = 1'b1;
                end
                if (fifo_pop && fifo_head[0]) begin
                    done_d  = 1'b1;
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            inflight_q   <= 1'b0;
            ret_last_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            ret_last_q   <= ret_last_d;
            prev_valid_q <= prev_valid_d;
            fail_q       <= fail_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        prev_int_q <= prev_int_d;
    end

    assign bus.rd_en       = rd_issue;
    assign bus.rd_addr     = rd_ptr_q[ADDR_W-1:0];
    assign bus.index_out   = fifo_head[ENTRY_W-1:1];
    assign bus.index_valid = out_valid;
    assign bus.index_last  = fifo_head[0] && out_valid;
    assign bus.done        = done_q;
    assign bus.fail        = fail_q;
endmodule

// File: tb/tb_field_ordering_dup_check.sv
// Randomized scoreboard bench for field_ordering_dup_check with a merge_sort read-port model.
module tb_field_ordering_dup_check;
    localparam int IW = 8;
    localparam int XW = 3;
    localparam int N  = 8;

    typedef struct {
        logic [XW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    field_ordering_dup_check_if #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(N)) bus ();

    field_ordering_dup_check #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;

    logic [IW-1:0]    keys [N];
    logic [XW-1:0]    idxs [N];
    logic [IW+XW-1:0] mem  [N];
    exp_t             expq [$];

    bit exp_fail;
    int exp_done_rel;
    int exp_first_rel;
    bit strict_drop;
    bit chk_rd_stop;
    int exp_addr;
    bit done_seen;
    bit first_seen;
    int last_rel;
    int rmode = 0;
    int rphase = 0;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // merge_sort read port: one-cycle read latency
    always @(posedge clk) begin
        if (bus.rd_en) bus.data_in <= mem[bus.rd_addr];
    end

    initial begin
        bus.index_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.index_ready = 1'b1;
                1: begin
                    bus.index_ready = (rphase % 3 == 0);
                    rphase++;
                end
                default: bus.index_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and judges each done pulse.
    logic          hold_q = 1'b0;
    logic [XW-1:0] pidx_q = '0;
    logic          plast_q = 1'b0;
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        rel = cyc - t0;
        if (rst_n) begin
            if (bus.rd_en) begin
                check("rd_addr", int'(bus.rd_addr), exp_addr);
                exp_addr++;
                if (chk_rd_stop) check("rd_after_dup", int'(rel <= 3), 1);
            end
            if (hold_q && bus.index_valid) begin
                check("hold_index", int'(bus.index_out), int'(pidx_q));
                check("hold_last", int'(bus.index_last), int'(plast_q));
            end
            if (bus.index_valid && bus.index_ready) begin
                if (expq.size() == 0) begin
                    check("extra_elem", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("index", int'(bus.index_out), int'(e.idx));
                    check("last", int'(bus.index_last), int'(e.last));
                end
                if (!first_seen && exp_first_rel >= 0) check("first_cycle", rel, exp_first_rel);
                first_seen = 1'b1;
                if (bus.index_last) begin
                    last_rel = rel;
                    if (exp_done_rel >= 0) check("last_cycle", rel, exp_done_rel - 1);
                end
            end
            if (bus.done) begin
                done_seen = 1'b1;
                check("fail_at_done", int'(bus.fail), int'(exp_fail));
                check("valid_at_done", int'(bus.index_valid), 0);
                if (exp_done_rel >= 0) check("done_cycle", rel, exp_done_rel);
                if (exp_fail) begin
                    if (strict_drop) check("dropped", expq.size(), 1);
                    else check("dropped_le1", int'(expq.size() <= 1), 1);
                end else begin
                    check("left_over", expq.size(), 0);
                    check("done_after_last", rel, last_rel + 1);
                end
                expq.delete();
            end
        end
        hold_q  = bus.index_valid && !bus.index_ready;
        pidx_q  = bus.index_out;
        plast_q = bus.index_last;
    end

    // Reference: every word is emitted in address order until the first key equal to its predecessor;
    // the word just before a duplicate may still be in the FIFO and be discarded.
    task automatic build_expect();
        exp_t e;
        expq.delete();
        exp_fail = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = {keys[i], idxs[i]};
        for (int i = 0; i < N; i++) begin
            if (i > 0 && keys[i] == keys[i-1]) begin
                exp_fail = 1'b1;
                break;
            end
            e.idx  = idxs[i];
            e.last = (i == N - 1);
            expq.push_back(e);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_rd_en"}, int'(bus.rd_en), 0);
        check({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        check({tag, "_index_valid"}, int'(bus.index_valid), 0);
        check({tag, "_index_out"}, int'(bus.index_out), 0);
        check({tag, "_index_last"}, int'(bus.index_last), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_fail"}, int'(bus.fail), 0);
    endtask

    task automatic begin_run(input int mode, input int done_rel, input int first_rel, input bit rd_stop);
        rmode = mode;
        rphase = 0;
        build_expect();
        exp_done_rel  = done_rel;
        exp_first_rel = first_rel;
        strict_drop   = (mode == 0);
        chk_rd_stop   = rd_stop;
        exp_addr   = 0;
        done_seen  = 1'b0;
        first_seen = 1'b0;
        last_rel   = -100;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("fail_clear_cycle1", int'(bus.fail), 0);
    endtask

    task automatic finish_run(string tag);
        for (int c = 0; c < 300 && !done_seen; c++) @(negedge clk);
        check({tag, "_done_seen"}, int'(done_seen), 1);
        chk_rd_stop = 1'b0;
    endtask

    task automatic set_odd_list();
        for (int i = 0; i < N; i++) begin
            keys[i] = IW'(2 * i + 1);
            idxs[i] = XW'(N - 1 - i);
        end
    endtask

    task automatic set_random_list(input bit allow_dup);
        int k;
        int j;
        logic [XW-1:0] tmp;
        k = $urandom_range(0, 15);
        for (int i = 0; i < N; i++) begin
            keys[i] = IW'(k);
            idxs[i] = XW'(i);
            k += $urandom_range(1, 30);
        end
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = idxs[i];
            idxs[i] = idxs[j];
            idxs[j] = tmp;
        end
        if (allow_dup && $urandom_range(0, 1) == 1) begin
            j = $urandom_range(1, N - 1);
            keys[j] = keys[j-1];
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data_in = '0;
        exp_done_rel = -1;
        exp_first_rel = -1;
        chk_rd_stop = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1;
        rst_n = 1'b1;

        // Distinct sorted keys, full throughput
        set_odd_list();
        begin_run(0, N + 3, 3, 1'b0);
        finish_run("odd_ready1");

        // Same list with 1,0,0 ready pattern
        set_odd_list();
        begin_run(1, -1, -1, 1'b0);
        finish_run("odd_toggle");

        // Duplicate at positions 0/1
        for (int i = 0; i < N; i++) begin
            keys[i] = 8'd4;
            idxs[i] = XW'(i);
        end
        begin_run(0, 4, -1, 1'b1);
        finish_run("dup01");
        repeat (3) @(negedge clk);
        check("fail_held", int'(bus.fail), 1);

        // Duplicate at positions 6/7
        set_odd_list();
        keys[N-1] = keys[N-2];
        begin_run(0, N + 2, 3, 1'b0);
        finish_run("dup67");

        // Reset in cycle 5, then a full run
        set_odd_list();
        begin_run(0, -1, 3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        expq.delete();
        set_odd_list();
        begin_run(0, N + 3, 3, 1'b0);
        finish_run("after_reset");

        // start pulsed mid-run is ignored
        set_odd_list();
        begin_run(0, N + 3, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_run("restart_ignored");

        // Randomized lists and back-pressure
        for (int r = 0; r < 40; r++) begin
            set_random_list(1'b1);
            begin_run(2, -1, -1, 1'b0);
            finish_run("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
